func_dispatch: RTL
==================

# func_dispatch

Operand dispatcher that sits directly upstream of the `func` datapath (y = a³ + ⌊√b⌋). It buffers incoming (a, b) operand pairs in a small FIFO and issues them one at a time over func's start/busy handshake. It captures each 24-bit result and presents it, with an 8-bit sequence tag, on a valid/ready output port. It decouples producers from func's multi-cycle, variable latency.

## Interface
- `DEPTH`, default 4: operand FIFO entries; power of two, 2..16.
- `TIMEOUT`, default 1023: maximum cycles spent in START+RUN for one job before abort; ≥ 16.

- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: operand pair valid.
- `in_ready_o` out 1: FIFO can accept; = (count != DEPTH).
- `in_a_i` in 8: operand a (cubed).
- `in_b_i` in 8: operand b (square-rooted).
- `f_start_o` out 1: start request to func.
- `f_a_o` out 8: operand a to func, stable from start until job end.
- `f_b_o` out 8: operand b to func, stable from start until job end.
- `f_busy_i` in 1: func busy.
- `f_y_i` in 24: func result, valid once busy has fallen.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts result.
- `out_y_o` out 24: captured result.
- `out_tag_o` out 8: job sequence number, in order of acceptance, wraps 255→0.
- `busy_o` out 1: FIFO non-empty, or FSM not IDLE, or out_valid_o high.
- `err_o` out 1: sticky timeout flag.

## Operation
- FIFO: DEPTH entries of {a, b}. Push on in_valid_i && in_ready_o. in_ready_o depends only on count; no push while full, even in the cycle a pop occurs.
- FSM states are IDLE, START and RUN. All FSM outputs are registered.
- IDLE: if FIFO non-empty && !out_valid_o, then:
  - load f_a_o/f_b_o from the head and pop;
  - set f_start_o=1 and clear the watchdog;
  - go to START.
  - Otherwise, hold.
- START: hold f_start_o=1 until f_busy_i is sampled 1, then set f_start_o=0 and go to RUN.
- RUN: on the first edge with f_busy_i=0, do all of the following and go to IDLE:
  - out_y_o<=f_y_i, out_tag_o<=tag, tag<=tag+1;
  - out_valid_o<=1.
- Output slot: out_valid_o clears on the edge where out_valid_o && out_ready_i. A new job is not issued until the slot is empty, so there is a single outstanding result and no overwrite.
- Watchdog counts cycles in START/RUN. On reaching TIMEOUT:
  - err_o<=1 (sticky until reset);
  - f_start_o<=0;
  - the job is discarded and tag still increments;
  - go to IDLE.
- Order is preserved: tags are strictly sequential per accepted input.
- Arithmetic lives in func. This block only transports the 24-bit result unchanged; the maximum value is 255³+15 = 0xFD030E.

## Timing
- Reset (rst_i=0, asynchronous): FIFO empty, state IDLE, tag=0. Every output is 0 except in_ready_o, which is 1 (combinational from count=0).
- Reset mid-job aborts immediately: f_start_o drops, FIFO contents and any pending output are discarded. The bench must not push while rst_i=0.
- Push at edge N into an empty FIFO with an empty output slot:
  - f_start_o=1 after edge N+1;
  - func sees start at edge N+2, so busy rises after N+2;
  - f_start_o=0 after edge N+3.
- out_valid_o rises after the first edge in RUN where f_busy_i=0. Total latency is func compute time + 4 cycles.
- Back-to-back issue: the next f_start_o can rise 1 cycle after out_valid_o clears.
- out_ready_i held high: out_valid_o is high for exactly 1 cycle per job.
- Simultaneous push and pop: both take effect when not full, and count is unchanged.
- Tag wraps 255→0 with no stall.

## Test plan
- Single job, a=3, b=16, out_ready_i=1 → out_y_o=31 (0x00001F), out_tag_o=0, one out_valid_o pulse; f_a_o/f_b_o stable from start until busy falls.
- Boundaries: a=0, b=0 → 0 (tag 0); a=255, b=255 → 0xFD030E (tag 1); a=1, b=1 → 2 (tag 2).
- Backpressure/full, DEPTH=4, out_ready_i=0, push (1,1),(2,4),(3,9),(4,16),(5,25),(6,36):
  - 5 pushes are accepted; in_ready_o=0 blocks the 6th.
  - Releasing out_ready_i yields 2, 10, 30, 68, 130 with tags 0–4 in order.
- Timeout: func model holds f_busy_i=1 forever → after 1023 cycles err_o=1 and f_start_o=0. The next job with a working model still completes, carrying tag 1.
- Reset mid-RUN with 2 entries queued → all outputs 0 asynchronously, in_ready_o=1, busy_o=0. After release, a new job (2,9) returns 11 with tag 0.
- Tag wrap: 257 jobs of (1,0) → all results 1; the 257th carries out_tag_o=0.

Source files
------------

// File: rtl/func_dispatch.sv
// Operand dispatcher in front of the func datapath: buffers (a, b) pairs, issues
// them over func's start/busy handshake and returns tagged 24-bit results.
module func_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_a_i,
  input  logic [7:0]  in_b_i,
  output logic        f_start_o,
  output logic [7:0]  f_a_o,
  output logic [7:0]  f_b_o,
  input  logic        f_busy_i,
  input  logic [23:0] f_y_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [23:0] out_y_o,
  output logic [7:0]  out_tag_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid holds its payload until then, and ready never depends on valid.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, RUN = 2'd2} state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   head;
  logic          push, pop;

  state_t        state_q, state_d;
  logic          f_start_d, out_valid_d, err_d;
  logic [7:0]    f_a_d, f_b_d, out_tag_d, tag_q, tag_d;
  logic [23:0]   out_y_d;
  logic [WW-1:0] wd_q, wd_d;

  assign in_ready_o  = (count != FULL);
  assign push        = in_valid_i && in_ready_o;
  assign head        = mem[rd_ptr];
  assign busy_o      = (count != '0) || (state_q != IDLE) || out_valid_o;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {in_a_i, in_b_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      f_start_o   <= 1'b0;
      f_a_o       <= '0;
      f_b_o       <= '0;
      out_valid_o <= 1'b0;
      out_y_o     <= '0;
      out_tag_o   <= '0;
      tag_q       <= '0;
      wd_q        <= '0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_start_o   <= f_start_d;
      f_a_o       <= f_a_d;
      f_b_o       <= f_b_d;
      out_valid_o <= out_valid_d;
      out_y_o     <= out_y_d;
      out_tag_o   <= out_tag_d;
      tag_q       <= tag_d;
      wd_q        <= wd_d;
      err_o       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    f_start_d   = f_start_o;
    f_a_d       = f_a_o;
    f_b_d       = f_b_o;
    out_valid_d = out_valid_o;
    out_y_d     = out_y_o;
    out_tag_d   = out_tag_o;
    tag_d       = tag_q;
    wd_d        = wd_q;
    err_d       = err_o;
    pop         = 1'b0;

    if (out_valid_o && out_ready_i) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Only one result may be outstanding, so wait for the slot to drain.
        if ((count != '0) && !out_valid_o) begin
          pop       = 1'b1;
          f_a_d     = head[15:8];
          f_b_d     = head[7:0];
          f_start_d = 1'b1;
          wd_d      = '0;
          state_d   = START;
        end
      end
      START, RUN: begin
        wd_d = wd_q + 1'b1;
        if ((state_q == START) && f_busy_i) begin
          f_start_d = 1'b0;
          state_d   = RUN;
        end else if ((state_q == RUN) && !f_busy_i) begin
          out_y_d     = f_y_i;
          out_tag_d   = tag_q;
          tag_d       = tag_q + 1'b1;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (wd_q == WD_LAST) begin
          // Abandon the job but consume its tag so later tags stay aligned with inputs.
          err_d     = 1'b1;
          f_start_d = 1'b0;
          tag_d     = tag_q + 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
